// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, default addresses and status bit positions for the MMIO UART transmitter
package uart_pkg;

  // Transmit framing FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Default register addresses
  localparam logic [31:0] DEF_DATA_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] DEF_STAT_ADDR = 32'hFFFF_FF04;

  // Status readback bit positions
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_BUSY_BIT  = 3;

  // Control write bit that clears the sticky overflow flag
  localparam int CTRL_CLR_OVF_BIT = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmitter, push/pop with same-edge push-when-full support
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees a slot on the same edge
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with FIFO, sticky overflow and status readback
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [31:0] UART_STAT_ADDR = DEF_STAT_ADDR,
  parameter int unsigned CLKS_PER_BIT   = 4,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        TX,
  output logic        Busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic          push, pop, clr_ovf;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          baud_last;
  logic          unused_bits;

  assign push        = MemWrite && (DataAdr == UART_DATA_ADDR);
  assign clr_ovf     = MemWrite && (DataAdr == UART_STAT_ADDR) && WriteData[CTRL_CLR_OVF_BIT];
  assign baud_last   = (baud_q == BAUD_LAST);
  assign unused_bits = ^{WriteData[31:8], fifo_count};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (push),
    .push_data (WriteData[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Framing next-state: baud divider, bit counter, shift register and FIFO pop requests
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state being entered so TX changes exactly on the transition edge
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped byte wins over a same-edge clear
  always_comb begin
    ovf_d = (push && fifo_full && !pop) || (ovf_q && !clr_ovf);
  end

  // FSM, counters, shift register, registered TX and overflow flag
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign TX   = tx_q;
  assign Busy = (state_q != ST_IDLE) || !fifo_empty;

  // Status readback decodes only the status address
  always_comb begin
    ReadData = '0;
    if (DataAdr == UART_STAT_ADDR) begin
      ReadData[STAT_EMPTY_BIT] = fifo_empty;
      ReadData[STAT_FULL_BIT]  = fifo_full;
      ReadData[STAT_OVF_BIT]   = ovf_q;
      ReadData[STAT_BUSY_BIT]  = Busy;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench: stores push expected bytes, a serial monitor decodes TX frames and compares
module tb_mmio_uart_tx;

  localparam int          CPB     = 4;
  localparam int          FRAME   = 10 * CPB;
  localparam logic [31:0] A_DATA  = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT  = 32'hFFFF_FF04;
  localparam logic [31:0] A_OTHER = 32'hFFFF_FF08;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        TX;
  logic        Busy;

  mmio_uart_tx #(
    .UART_DATA_ADDR (A_DATA),
    .UART_STAT_ADDR (A_STAT),
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH     (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .TX        (TX),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_store_cyc = 0;

  logic [7:0] sb_exp[$];
  int         start_cycs[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serial monitor state
  logic samp [FRAME];
  int   mon_idx    = 0;
  bit   mon_active = 1'b0;

  task automatic check_frame();
    logic [7:0] got;
    logic [9:0] lvl;
    logic [7:0] want;
    int errs;
    errs = 0;
    for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB + CPB / 2];
    lvl = {1'b1, got, 1'b0};
    for (int j = 0; j < FRAME; j++) if (samp[j] !== lvl[j / CPB]) errs++;
    check("frame_shape", errs, 0);
    if (sb_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_frame: got byte %h expected no frame", got);
    end else begin
      want = sb_exp.pop_front();
      check("frame_byte", {24'h0, got}, {24'h0, want});
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (TX === 1'b0) begin
        mon_active = 1'b1;
        samp[0]    = TX;
        mon_idx    = 1;
        start_cycs.push_back(cyc);
      end
    end else begin
      samp[mon_idx] = TX;
      mon_idx++;
      if (mon_idx == FRAME) begin
        mon_active = 1'b0;
        check_frame();
      end
    end
  end

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    DataAdr   = adr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge CLK);
    #1;
    MemWrite       = 1'b0;
    last_store_cyc = cyc;
  endtask

  task automatic wait_busy_low(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (!Busy) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (start_cycs.size() >= n) return;
      @(negedge CLK);
    end
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    DataAdr = A_STAT;
    #1;
    check(name, ReadData, exp);
  endtask

  initial begin
    int n0, s0, at, k1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx", {31'h0, TX}, 32'h1);
    check("reset_busy", {31'h0, Busy}, 32'h0);
    read_stat("reset_stat", 32'h1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Single byte: A5 with junk upper bits
    n0 = start_cycs.size();
    sb_exp.push_back(8'hA5);
    store(A_DATA, 32'h0000_01A5);
    s0 = last_store_cyc;
    wait_starts(n0 + 1, 20);
    if (start_cycs.size() > n0) check("single_latency", start_cycs[n0], s0 + 1);
    else check("single_start_timeout", start_cycs.size(), n0 + 1);
    wait_busy_low(100, at);
    check("single_busy_fall", at, s0 + 1 + FRAME);

    // Back-to-back frames
    @(negedge CLK);
    n0 = start_cycs.size();
    sb_exp.push_back(8'h55);
    sb_exp.push_back(8'h0F);
    store(A_DATA, 32'h55);
    s0 = last_store_cyc;
    store(A_DATA, 32'h0F);
    wait_busy_low(200, at);
    if (start_cycs.size() >= n0 + 2) begin
      check("b2b_first_start", start_cycs[n0], s0 + 1);
      check("b2b_gap", start_cycs[n0 + 1] - start_cycs[n0], FRAME);
      check("b2b_total", at - start_cycs[n0], 2 * FRAME);
    end else begin
      check("b2b_frames_seen", start_cycs.size(), n0 + 2);
    end

    // Address decode: other address has no effect, data address reads zero
    n0 = start_cycs.size();
    store(A_OTHER, 32'h77);
    DataAdr = A_DATA;
    #1;
    check("read_data_addr", ReadData, 32'h0);
    read_stat("stat_after_other", 32'h1);
    repeat (60) @(negedge CLK);
    check("no_frame_other", start_cycs.size(), n0);

    // Overflow: ten consecutive stores, nine accepted
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb_exp.push_back(8'(8'h10 + i));
      store(A_DATA, 32'hABCD_0010 + 32'(i));
      if (i == 0) k1 = last_store_cyc;
    end
    read_stat("ovf_status", 32'hE);
    store(A_STAT, 32'h4);
    read_stat("ovf_clear", 32'hA);

    // Full FIFO with a push on the exact STOP-final edge of the first frame
    while (cyc < k1 + FRAME) begin
      @(posedge CLK);
      #1;
    end
    read_stat("pre_pop_full", 32'hA);
    sb_exp.push_back(8'h5A);
    store(A_DATA, 32'h5A);
    read_stat("full_pop_push", 32'hA);
    wait_busy_low(9 * FRAME + 50, at);
    check("drain_done", {31'h0, at != -1}, 32'h1);
    read_stat("stat_after_drain", 32'h1);
    check("sb_empty_after_drain", sb_exp.size(), 0);

    // Mid-frame reset during data bit 3 of C3 (bit 3 is 0)
    @(negedge CLK);
    n0 = start_cycs.size();
    sb_exp.push_back(8'hC3);
    store(A_DATA, 32'hC3);
    k1 = last_store_cyc;
    while (cyc < k1 + 18) begin
      @(posedge CLK);
      #1;
    end
    #1;
    check("tx_bit3_low", {31'h0, TX}, 32'h0);
    RESET = 1'b0;
    #1;
    check("rst_tx_async", {31'h0, TX}, 32'h1);
    check("rst_busy_async", {31'h0, Busy}, 32'h0);
    sb_exp.delete();
    store(A_DATA, 32'h99);
    RESET = 1'b1;
    repeat (100) @(negedge CLK);
    check("rst_no_more_frames", start_cycs.size(), n0 + 1);
    check("rst_busy_after", {31'h0, Busy}, 32'h0);
    check("rst_tx_idle", {31'h0, TX}, 32'h1);
    read_stat("rst_stat", 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
